// File: rtl/audio_filter_seq_if.sv
// audio_filter_seq_if: strobe, channel data, filter handshake, RAM write and PCM result signals
interface audio_filter_seq_if #(parameter int NCH = 2);
  logic              stb_pcm;
  logic [NCH*24-1:0] ch_data;
  logic              flt_stb_start;
  logic              flt_busy;
  logic [9:0]        flt_addr_start;
  logic [23:0]       flt_din;
  logic [15:0]       flt_out;
  logic              flt_wr_en;
  logic [9:0]        flt_wr_addr;
  logic [23:0]       flt_wr_data;
  logic              ram_wr_en;
  logic [9:0]        ram_wr_addr;
  logic [23:0]       ram_wr_data;
  logic [NCH*16-1:0] pcm_out;
  logic              pcm_valid;
  logic              overrun;
  logic              busy;
  modport master(
    input  stb_pcm, ch_data, flt_busy, flt_out, flt_wr_en, flt_wr_addr, flt_wr_data,
    output flt_stb_start, flt_addr_start, flt_din, ram_wr_en, ram_wr_addr, ram_wr_data,
           pcm_out, pcm_valid, overrun, busy
  );
  modport slave(
    output stb_pcm, ch_data, flt_busy, flt_out, flt_wr_en, flt_wr_addr, flt_wr_data,
    input  flt_stb_start, flt_addr_start, flt_din, ram_wr_en, ram_wr_addr, ram_wr_data,
           pcm_out, pcm_valid, overrun, busy
  );
endinterface

// File: rtl/audio_filter_seq.sv
// audio_filter_seq: time-multiplexes one audio_filter across NCH channels and clears its state RAM after reset
module audio_filter_seq #(
  parameter int NCH  = 2,
  parameter int SLOT = 8
) (
  input logic clk,
  input logic rst,
  audio_filter_seq_if.master bus
);
  typedef enum logic [2:0] {DRAIN, CLEAR, IDLE, START, WAIT_UP, WAIT_DN, NEXT} state_t;
  localparam logic [9:0] LAST    = 10'(NCH*SLOT-1);
  localparam logic [1:0] CH_LAST = 2'(NCH-1);
  state_t            state, state_n;
  logic [1:0]        ch;
  logic [9:0]        clr_cnt;
  logic [NCH*24-1:0] snap;
  logic [NCH*16-1:0] pcm_q;
  logic              valid_q, ovr_q, init;
  // state register
  always_ff @(posedge clk) state <= rst ? DRAIN : state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      DRAIN:   state_n = bus.flt_busy ? DRAIN : CLEAR;
      CLEAR:   state_n = clr_cnt == LAST ? IDLE : CLEAR;
      IDLE:    state_n = bus.stb_pcm ? START : IDLE;
      START:   state_n = WAIT_UP;
      WAIT_UP: state_n = bus.flt_busy ? WAIT_DN : WAIT_UP;
      WAIT_DN: state_n = bus.flt_busy ? WAIT_DN : NEXT;
      NEXT:    state_n = ch == CH_LAST ? IDLE : START;
      default: state_n = DRAIN;
    endcase
  end
  // clear counter, snapshot, channel index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      clr_cnt <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      clr_cnt <= state == CLEAR ? clr_cnt + 10'd1 : clr_cnt;
      valid_q <= state == NEXT && ch == CH_LAST;
      ovr_q   <= ovr_q | (bus.stb_pcm && !(state inside {IDLE, DRAIN, CLEAR}));
      if (state == IDLE && bus.stb_pcm) begin
        snap <= bus.ch_data;
        ch   <= '0;
      end
      if (state == WAIT_DN && !bus.flt_busy) pcm_q[16*ch +: 16] <= bus.flt_out;
      if (state == NEXT && ch != CH_LAST) ch <= ch + 2'd1;
    end
  end
  assign init               = state == DRAIN || state == CLEAR;
  assign bus.flt_stb_start  = state == START;
  assign bus.flt_addr_start = 10'(ch) * 10'(SLOT);
  assign bus.flt_din        = snap[24*ch +: 24];
  assign bus.ram_wr_en      = init ? state == CLEAR : bus.flt_wr_en;
  assign bus.ram_wr_addr    = init ? clr_cnt : bus.flt_wr_addr;
  assign bus.ram_wr_data    = init ? 24'd0 : bus.flt_wr_data;
  assign bus.pcm_out        = pcm_q;
  assign bus.pcm_valid      = valid_q;
  assign bus.overrun        = ovr_q;
  assign bus.busy           = state != IDLE;
endmodule
